// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: datapath width, fetch FSM encoding and
// the default reset vector.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_PC = 3'd3,
        ST_TRAP    = 3'd4
    } fetch_state_t;

    // Instruction addresses must be word aligned (no compressed ISA).
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-free adder with carry out, shared across the datapath.
module adder32
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one word per
// instruction, offers it to decode and waits for the branch unit's next PC.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            pc_load,
    input  logic [XLEN-1:0] res_pc,
    output logic            fetch_err,
    output logic [XLEN-1:0] instret
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_inst_valid;
    logic            r_imem_req;
    logic            r_fetch_err;
    logic [XLEN-1:0] r_instret;

    logic [XLEN-1:0] w_instret_next;
    logic            w_unused_carry;
    logic            w_load_accept;

    adder32 u_instret_inc (
        .a    (r_instret),
        .b    (32'h0000_0001),
        .sum  (w_instret_next),
        .cout (w_unused_carry)
    );

    // A load is taken in WAIT_PC, or in ISSUE when decode accepts in the same cycle.
    assign w_load_accept = pc_load &&
                           ((r_state == ST_WAIT_PC) ||
                            ((r_state == ST_ISSUE) && inst_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_instret    <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_inst       <= imem_rdata;
                        r_imem_req   <= 1'b0;
                        r_inst_valid <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= ST_WAIT_PC;
                    end
                end
                ST_WAIT_PC: begin
                    r_state <= ST_WAIT_PC;
                end
                ST_TRAP: begin
                    r_imem_req   <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_TRAP;
                end
            endcase

            // NOTE: non-blocking updates resolve last-write-wins, so this block
            // overrides the ISSUE->WAIT_PC transition above on a fused load.
            if (w_load_accept) begin
                r_instret <= w_instret_next;
                if (is_word_aligned(res_pc)) begin
                    r_pc       <= res_pc;
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end else begin
                    r_fetch_err <= 1'b1;
                    r_state     <= ST_TRAP;
                end
            end
        end
    end

    assign pc         = r_pc;
    assign imem_addr  = r_pc;
    assign imem_req   = r_imem_req;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign fetch_err  = r_fetch_err;
    assign instret    = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vectors with a scoreboard of
// expected outputs, plus reset, trap and instret-wrap sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] res_pc = '0;
    logic        fetch_err;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        req;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] instret;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        load;
        logic [31:0] res_pc;
        exp_t        exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc_load    (pc_load),
        .res_pc     (res_pc),
        .fetch_err  (fetch_err),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t e(input logic req, input logic valid, input logic [31:0] ins,
                               input logic [31:0] p, input logic [31:0] ret, input logic err);
        exp_t x;
        x.req = req; x.valid = valid; x.inst = ins; x.pc = p; x.instret = ret; x.err = err;
        return x;
    endfunction

    function automatic vec_t v(input logic ack, input logic [31:0] rdata, input logic ready,
                               input logic load, input logic [31:0] rpc, input exp_t x);
        vec_t t;
        t.ack = ack; t.rdata = rdata; t.ready = ready; t.load = load; t.res_pc = rpc; t.exp = x;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t x);
        check({tag, ".imem_req"},   {31'd0, imem_req},   {31'd0, x.req});
        check({tag, ".imem_addr"},  imem_addr,           x.pc);
        check({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, x.valid});
        check({tag, ".inst"},       inst,                x.inst);
        check({tag, ".pc"},         pc,                  x.pc);
        check({tag, ".instret"},    instret,             x.instret);
        check({tag, ".fetch_err"},  {31'd0, fetch_err},  {31'd0, x.err});
    endtask

    // Drive one cycle of inputs, then compare the outputs after the next edge.
    task automatic apply(input string tag, input vec_t t);
        exp_t x;
        imem_ack   = t.ack;
        imem_rdata = t.rdata;
        inst_ready = t.ready;
        pc_load    = t.load;
        res_pc     = t.res_pc;
        sb.push_back(t.exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            x = sb.pop_front();
            check_outs(tag, x);
        end
    endtask

    task automatic set_idle();
        imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; pc_load = 1'b0; res_pc = '0;
    endtask

    // Called just after a posedge: reset mid-cycle, check asynchronously, release on negedge.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(tag, e(0, 0, 32'h0, 32'h0, 32'h0, 0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Fused single-cycle path.
        tbl.push_back(v(0, 32'h0,        0, 0, 32'h0,   e(1, 0, 32'h13,       32'h0,   32'd0, 0)));
        tbl[0].exp.inst = 32'h0;
        tbl.push_back(v(1, 32'h13,       0, 0, 32'h0,   e(0, 1, 32'h13,       32'h0,   32'd0, 0)));
        tbl.push_back(v(0, 32'h0,        1, 1, 32'h4,   e(1, 0, 32'h13,       32'h4,   32'd1, 0)));
        // Ack delayed 5 cycles, ready delayed 3 cycles.
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 32'h0,    0, 0, 32'h0,   e(1, 0, 32'h13,       32'h4,   32'd1, 0)));
        tbl.push_back(v(1, 32'h00500093, 0, 0, 32'h0,   e(0, 1, 32'h00500093, 32'h4,   32'd1, 0)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 32'h0,    0, 0, 32'h0,   e(0, 1, 32'h00500093, 32'h4,   32'd1, 0)));
        tbl.push_back(v(0, 32'h0,        1, 0, 32'h0,   e(0, 0, 32'h00500093, 32'h4,   32'd1, 0)));
        tbl.push_back(v(0, 32'h0,        0, 0, 32'h0,   e(0, 0, 32'h00500093, 32'h4,   32'd1, 0)));
        tbl.push_back(v(0, 32'h0,        0, 1, 32'h8,   e(1, 0, 32'h00500093, 32'h8,   32'd2, 0)));
        // Loads ignored in FETCH and in ISSUE without ready; ack/ready ignored in WAIT_PC.
        tbl.push_back(v(0, 32'h0,        0, 1, 32'h200, e(1, 0, 32'h00500093, 32'h8,   32'd2, 0)));
        tbl.push_back(v(1, 32'h6f,       0, 1, 32'h300, e(0, 1, 32'h6f,       32'h8,   32'd2, 0)));
        tbl.push_back(v(0, 32'h0,        0, 1, 32'h400, e(0, 1, 32'h6f,       32'h8,   32'd2, 0)));
        tbl.push_back(v(0, 32'h0,        1, 0, 32'h0,   e(0, 0, 32'h6f,       32'h8,   32'd2, 0)));
        tbl.push_back(v(1, 32'hdead,     1, 0, 32'h0,   e(0, 0, 32'h6f,       32'h8,   32'd2, 0)));
        tbl.push_back(v(0, 32'h0,        0, 1, 32'h100, e(1, 0, 32'h6f,       32'h100, 32'd3, 0)));
        // Misaligned target traps; later acks and loads have no effect.
        tbl.push_back(v(1, 32'h13,       0, 0, 32'h0,   e(0, 1, 32'h13,       32'h100, 32'd3, 0)));
        tbl.push_back(v(0, 32'h0,        1, 1, 32'h102, e(0, 0, 32'h13,       32'h100, 32'd4, 1)));
        tbl.push_back(v(1, 32'haa,       0, 1, 32'h8,   e(0, 0, 32'h13,       32'h100, 32'd4, 1)));
        tbl.push_back(v(1, 32'hbb,       1, 1, 32'h10,  e(0, 0, 32'h13,       32'h100, 32'd4, 1)));

        #12;
        check_outs("reset", e(0, 0, 32'h0, 32'h0, 32'h0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        check_outs("boot", e(0, 0, 32'h0, 32'h0, 32'h0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Reset clears the trap.
        pulse_reset("trap_reset");

        // Reset dropped while a request at a non-reset address is pending.
        apply("ar0", v(0, 32'h0,  0, 0, 32'h0,  e(1, 0, 32'h0,  32'h0,  32'd0, 0)));
        apply("ar1", v(1, 32'h13, 0, 0, 32'h0,  e(0, 1, 32'h13, 32'h0,  32'd0, 0)));
        apply("ar2", v(0, 32'h0,  1, 1, 32'h40, e(1, 0, 32'h13, 32'h40, 32'd1, 0)));
        apply("ar3", v(0, 32'h0,  0, 0, 32'h0,  e(1, 0, 32'h13, 32'h40, 32'd1, 0)));
        imem_ack = 1'b1;
        imem_rdata = 32'h77;
        pulse_reset("async_reset");
        check_outs("post_release", e(0, 0, 32'h0, 32'h0, 32'h0, 0));
        apply("ar4", v(1, 32'h77, 0, 0, 32'h0,  e(1, 0, 32'h0,  32'h0,  32'd0, 0)));

        // instret wrap from all-ones.
        apply("wr0", v(1, 32'h13, 0, 0, 32'h0,  e(0, 1, 32'h13, 32'h0,  32'd0, 0)));
        apply("wr1", v(0, 32'h0,  1, 0, 32'h0,  e(0, 0, 32'h13, 32'h0,  32'd0, 0)));
        set_idle();
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        apply("wr2", v(0, 32'h0,  0, 1, 32'h8,  e(1, 0, 32'h13, 32'h8,  32'd0, 0)));

        set_idle();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
